// File: rtl/serial_pkg.sv
// Line-level constants and FSM state encoding shared by the serial link
// receiver and transmitter.
package serial_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'b00;
  localparam state_t DATA = 2'b01;
  localparam state_t STOP = 2'b10;
  localparam state_t WAIT = 2'b11;

  localparam logic LINE_IDLE = 1'b0;
  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both flops reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_rx.sv
// Single-wire serial receiver with a valid/ready holding register.
// Define SERIAL_RX_SYNC_EN to put a 2-flop synchronizer in front of the FSM.
//
// state | meaning
// IDLE  | line idle, waiting for a start bit
// DATA  | shifting in DATA_BITS payload bits, LSB first
// STOP  | sampling the stop bit, delivering or dropping the word
// WAIT  | bad stop bit seen, waiting for the line to return low
module serial_rx
  import serial_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic [1:0]           s
);

  localparam int CNT_W = $clog2(DATA_BITS) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  state_t               state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 rxd_s;

`ifdef SERIAL_RX_SYNC_EN
  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );
`else
  assign rxd_s = rxd;
`endif

  assign s = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // A good frame landing in the same cycle re-asserts valid below.
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (rxd_s == START_BIT) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          for (int i = 0; i < DATA_BITS; i++) begin
            if (bit_cnt == CNT_W'(i)) shreg[i] <= rxd_s;
          end
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (bit_cnt == LAST_BIT) state <= STOP;
        end
        STOP: begin
          if (rxd_s == STOP_BIT) begin
            if (!rx_valid || rx_ready) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
            state <= IDLE;
          end else begin
            frame_err <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (rxd_s == LINE_IDLE) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// Self-checking bench for serial_rx: directed frames with literal expectations,
// then a randomized frame stream checked against a frame-level reference model.
module tb_serial_rx #(
  parameter int DB = 8
);
  import serial_pkg::*;

`ifdef SERIAL_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int NCYC = 2000;

  logic          clk = 1'b0;
  logic          rst;
  logic          rxd;
  logic          rx_ready;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          overrun;
  logic [1:0]    s;

  int checks   = 0;
  int failures = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  logic [DB-1:0] acc_q[$];

  // Stimulus schedule and frame-level annotations for the random phase.
  logic        line_a[NCYC];
  logic        rdy_a[NCYC];
  int          ev_a[NCYC];     // 0 none, 1 good stop sampled, 2 bad stop sampled
  logic [15:0] wd_a[NCYC];
  logic [1:0]  st_a[NCYC];

  serial_rx #(.DATA_BITS(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .s         (s)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (rx_valid && rx_ready) acc_q.push_back(rx_data);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic b, input logic r);
    rxd      = b;
    rx_ready = r;
    @(posedge clk);
    #1;
  endtask

  // Trailing LAT cycles repeat the stop level so the FSM samples the stop bit
  // on the last edge of this task (rdy_last applies on that edge).
  task automatic send_frame(input logic [15:0] w, input logic stopb,
                            input logic rdy_bits, input logic rdy_last);
    cyc(START_BIT, rdy_bits);
    for (int i = 0; i < DB; i++) cyc(w[i], rdy_bits);
    cyc(stopb, (LAT == 0) ? rdy_last : rdy_bits);
    for (int i = 0; i < LAT; i++) cyc(stopb, (i == LAT - 1) ? rdy_last : rdy_bits);
  endtask

  initial begin
    logic [15:0] w;
    logic [31:0] mask;
    int f0, o0, t, p, h, nframes, thr;
    logic          v;
    logic [DB-1:0] d;
    int e, k, nload, novr, nferr;
    logic ef, eo;
    logic [1:0] es;

    mask = (32'd1 << DB) - 32'd1;
    rst = 1'b1; rxd = 1'b0; rx_ready = 1'b0;
    #12;
    chk("reset_valid", rx_valid, 0);
    chk("reset_data", rx_data, 0);
    chk("reset_state", s, IDLE);
    chk("reset_ferr", frame_err, 0);
    chk("reset_ovr", overrun, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic frame 0xA5 with exact latency check
    f0 = ferr_cnt; o0 = ovr_cnt;
    w = 16'hA5;
    cyc(0, 0); cyc(0, 0); cyc(1, 0);
    for (int i = 0; i < DB; i++) cyc(w[i], 0);
    for (int j = 0; j <= LAT; j++) begin
      if (j == LAT) chk("basic_pre_valid", rx_valid, 0);
      cyc(0, 0);
    end
    chk("basic_valid", rx_valid, 1);
    chk("basic_data", rx_data, 32'hA5 & mask);
    cyc(0, 0);
    chk("basic_no_ferr", ferr_cnt - f0, 0);
    chk("basic_no_ovr", ovr_cnt - o0, 0);
    chk("basic_idle", s, IDLE);

    // Handshake
    cyc(0, 1);
    chk("hs_valid_drop", rx_valid, 0);
    chk("hs_data_hold", rx_data, 32'hA5 & mask);

    // Back-to-back with ready held high
    acc_q.delete();
    send_frame(16'h3C, STOP_BIT, 1, 1);
    send_frame(16'hC3, STOP_BIT, 1, 1);
    cyc(0, 1); cyc(0, 1);
    chk("b2b_count", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      chk("b2b_first", acc_q[0], 32'h3C & mask);
      chk("b2b_second", acc_q[1], 32'hC3 & mask);
    end
    chk("b2b_valid_clear", rx_valid, 0);

    // Overrun
    send_frame(16'h11, STOP_BIT, 0, 0);
    chk("ovr_first_valid", rx_valid, 1);
    chk("ovr_first_data", rx_data, 32'h11 & mask);
    o0 = ovr_cnt;
    send_frame(16'h22, STOP_BIT, 0, 0);
    cyc(0, 0);
    chk("ovr_pulse_once", ovr_cnt - o0, 1);
    chk("ovr_data_kept", rx_data, 32'h11 & mask);
    chk("ovr_valid_kept", rx_valid, 1);
    send_frame(16'h22, STOP_BIT, 0, 1);
    cyc(0, 0);
    chk("ovr_ready_data", rx_data, 32'h22 & mask);
    chk("ovr_ready_valid", rx_valid, 1);
    chk("ovr_ready_no_pulse", ovr_cnt - o0, 1);
    cyc(0, 1);
    chk("ovr_drain", rx_valid, 0);

    // Framing error
    f0 = ferr_cnt;
    send_frame(16'hFF, 1'b1, 0, 0);
    chk("ferr_wait_entry", s, WAIT);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0);
      chk("ferr_wait_hold", s, WAIT);
    end
    for (int i = 0; i <= LAT; i++) cyc(0, 0);
    chk("ferr_back_idle", s, IDLE);
    chk("ferr_pulse_once", ferr_cnt - f0, 1);
    chk("ferr_no_valid", rx_valid, 0);
    chk("ferr_data_kept", rx_data, 32'h22 & mask);
    send_frame(16'h5A, STOP_BIT, 0, 0);
    chk("ferr_next_valid", rx_valid, 1);
    chk("ferr_next_data", rx_data, 32'h5A & mask);

    // Reset mid-frame
    w = 16'h81;
    cyc(1, 0);
    for (int i = 0; i < 4; i++) cyc(w[i], 0);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_valid", rx_valid, 0);
    chk("rstmid_data", rx_data, 0);
    chk("rstmid_state", s, IDLE);
    chk("rstmid_ferr", frame_err, 0);
    chk("rstmid_ovr", overrun, 0);
    rxd = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    send_frame(16'h81, STOP_BIT, 0, 0);
    chk("rstmid_after_valid", rx_valid, 1);
    chk("rstmid_after_data", rx_data, 32'h81 & mask);

    // Random phase: build a frame-level schedule
    for (int c = 0; c < NCYC; c++) begin
      line_a[c] = LINE_IDLE;
      ev_a[c]   = 0;
      wd_a[c]   = '0;
      st_a[c]   = IDLE;
      thr       = (c / 250) % 4;
      rdy_a[c]  = ($urandom_range(0, 3) < thr);
    end
    t = 0; nframes = 0;
    while (t < NCYC - DB - 16) begin
      t += $urandom_range(0, 2);
      w = 16'($urandom) & mask[15:0];
      line_a[t] = START_BIT;
      st_a[t]   = DATA;
      for (int i = 0; i < DB; i++) begin
        line_a[t+1+i] = w[i];
        st_a[t+1+i]   = (i == DB - 1) ? STOP : DATA;
      end
      p = t + DB + 1;
      if ($urandom_range(0, 5) != 0) begin
        line_a[p] = STOP_BIT; ev_a[p] = 1; wd_a[p] = w; st_a[p] = IDLE;
        t = p + 1;
      end else begin
        line_a[p] = 1'b1; ev_a[p] = 2; st_a[p] = WAIT;
        h = $urandom_range(0, 5);
        for (int i = 0; i < h; i++) begin
          line_a[p+1+i] = 1'b1;
          st_a[p+1+i]   = WAIT;
        end
        line_a[p+1+h] = LINE_IDLE; st_a[p+1+h] = IDLE;
        t = p + 2 + h;
      end
      nframes++;
    end

    rst = 1'b1; rxd = 1'b0; rx_ready = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    v = 1'b0; d = '0; nload = 0; novr = 0; nferr = 0;
    for (int c = 0; c < NCYC; c++) begin
      cyc(line_a[c], rdy_a[c]);
      k  = c - LAT;
      e  = (k >= 0) ? ev_a[k] : 0;
      es = (k >= 0) ? st_a[k] : IDLE;
      ef = 1'b0; eo = 1'b0;
      if (e == 1) begin
        if (!v || rdy_a[c]) begin
          v = 1'b1; d = wd_a[k][DB-1:0]; nload++;
        end else begin
          eo = 1'b1; novr++;
        end
      end else begin
        if (e == 2) begin ef = 1'b1; nferr++; end
        if (v && rdy_a[c]) v = 1'b0;
      end
      chk("rnd_valid", rx_valid, v);
      chk("rnd_data", rx_data, d);
      chk("rnd_ferr", frame_err, ef);
      chk("rnd_ovr", overrun, eo);
      chk("rnd_state", s, es);
    end
    chk("rnd_frame_accounting", nload + novr + nferr, nframes);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
